mpsoc_wb_arbiter_rr: RTL and testbench
======================================

// Module: mpsoc_wb_arbiter_rr
// PURPOSE
//  Shares one Wishbone B3 slave port between NM masters (BFM masters, CPU/DMA ports).
//  Round-robin grant held for a whole cycle (wb_cyc high), so classic and CTI bursts are never split.
//  A per-grant watchdog terminates stalled transfers with an error to the master.
//  Sits between master ports and a single slave or decoder.
// PARAMETERS
//  NM       4    number of masters (2..16)
//  AW       32   address width
//  DW       32   data width (multiple of 8)
//  TIMEOUT  256  cycles that stb may wait for ack/err/rty before forced err; 0 disables
// PORTS
//  wb_clk_i    in   1         clock; all state changes on rising edge
//  wb_rst_ni   in   1         reset, synchronous, active-low
//  m_adr_i     in   NM*AW     master addresses, master k at [k*AW +: AW]
//  m_dat_i     in   NM*DW     master write data
//  m_sel_i     in   NM*DW/8   master byte selects
//  m_we_i      in   NM        master write enables
//  m_cyc_i     in   NM        master cycle requests
//  m_stb_i     in   NM        master strobes
//  m_cti_i     in   NM*3      master cycle type identifiers
//  m_bte_i     in   NM*2      master burst type extensions
//  m_dat_o     out  DW        slave read data, broadcast to all masters
//  m_ack_o     out  NM        ack, granted master only
//  m_err_o     out  NM        err, granted master only (slave err OR watchdog)
//  m_rty_o     out  NM        rty, granted master only
//  s_adr_o s_dat_o s_sel_o s_we_o s_cyc_o s_stb_o s_cti_o s_bte_o   out   slave-side copies of granted master
//  s_dat_i s_ack_i s_err_i s_rty_i                                 in    slave responses
//  gnt_o       out  NM        one-hot grant, registered
//  gnt_vld_o   out  1         grant valid, registered
// BEHAVIOUR
//  Reset (wb_rst_ni=0 at edge): state IDLE, gnt_o=0, gnt_vld_o=0, rr pointer=0, watchdog=0.
//  While reset: all s_* outputs 0 and all m_ack/err/rty 0 (combinational from gnt_vld_o=0).
//  FSM IDLE -> BUSY
//   - Condition: at an edge with any m_cyc_i set.
//   - Grant: first requester at or after rr pointer, ascending with wrap (rr pointer itself gets highest priority).
//   - Latency: 1 cycle from request to gnt_vld_o.
//  FSM BUSY -> BUSY (handover)
//   - Condition: at an edge with m_cyc_i[gnt]=0 and another master requesting.
//   - Arbitration restarts from gnt+1 (mod NM); new grant visible next cycle, no idle cycle.
//  FSM BUSY -> IDLE
//   - Condition: m_cyc_i[gnt]=0 and no other request; rr pointer <= gnt+1.
//   - On handover, rr pointer <= old gnt+1.
//  Grant is never revoked while m_cyc_i[gnt]=1, including across CTI 001/010 bursts and retries.
//  Muxing (BUSY)
//   - s_* outputs = granted master fields, combinational.
//   - s_cyc_o = m_cyc_i[gnt] & gnt_vld_o; s_stb_o likewise.
//  Muxing (IDLE): s_* outputs all 0.
//  Responses
//   - s_ack_i/s_err_i/s_rty_i routed to the granted bit only.
//   - Non-granted masters see 0.
//   - m_dat_o = s_dat_i unconditionally.
//  Watchdog (TIMEOUT>0)
//   - Counter clears on grant change, on any slave response, or when s_stb_o=0.
//   - Increments each cycle s_stb_o=1 without a response.
//   - On reaching TIMEOUT-1: m_err_o[gnt]=1 for exactly one cycle; s_stb_o and s_cyc_o forced 0 that cycle; counter clears.
//   - Counter width is $clog2(TIMEOUT+1); saturates, never wraps.
//  Simultaneous events
//   - A slave response arriving in the timeout cycle wins: no forced err, counter clears.
//   - A master dropping cyc in the same cycle as its ack is legal and releases at that edge.
//  Reset mid-transfer: grant drops next edge; the slave sees cyc fall; no response is forwarded.
// STRUCTURE
//  Package mpsoc_wb_arb_pkg
//   - Contents: state enum {ARB_IDLE, ARB_BUSY}; CTI_CLASSIC/CONST/INCR/EOB and BTE encodings shared with the BFM.
//   - Function rr_pick(req, ptr) returning one-hot.
//  Sub-module mpsoc_wb_rr_sel
//   - Combinational round-robin picker: req[NM], ptr[$clog2(NM)] -> onehot[NM], any.
//   - Implemented with doubled request vector and priority encode.
//  Top holds FSM, grant/pointer registers, watchdog counter and output muxes.
// TESTING (NM=4, TIMEOUT=16, BFM masters + BFM memory slave)
//  1. m0 single write 0x100=0xDEADBEEF, sel=0xF.
//     -> gnt_o=0001 one cycle after cyc; slave sees identical adr/dat/sel; m_ack_o[0] only; read back matches.
//  2. m0..m3 assert cyc same cycle after reset.
//     -> grants in order 0,1,2,3, each 1-cycle handover, no idle cycle between.
//  3. m1 8-beat INCR burst (cti 010, bte 00) at 0x200 while m2 requests.
//     -> m1 keeps grant through cti=111 beat; m2 granted the cycle after m1 drops cyc.
//  4. Slave never acks m3 read.
//     -> m_err_o[3]=1 on 16th stb cycle for one cycle; s_cyc_o=0 that cycle; counter restarts.
//  5. wb_rst_ni low for 1 cycle during m0 burst beat 3.
//     -> gnt_vld_o=0, all s_* 0 next cycle; after release, pending requests arbitrated from m0.
//  6. m2 only requester repeatedly (cyc pulses, 1 idle cycle apart).
//     -> each pulse granted to m2; rr pointer ends at 3; no starvation of later m0 request beyond one m2 cycle.

Source files
------------

// File: rtl/mpsoc_wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM state
// encoding, Wishbone B3 cycle-type / burst-type codes (also used by the
// bus functional models), and a reference round-robin pick helper.
package mpsoc_wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Cycle type identifiers (CTI)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extensions (BTE)
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    localparam int unsigned RR_MAX_NM  = 16;

    // First requester at or after ptr (ascending, wrapping at nm); one-hot result.
    function automatic logic [RR_MAX_NM-1:0] rr_pick(
        input logic [RR_MAX_NM-1:0] req,
        input logic [3:0]           ptr,
        input int unsigned          nm
    );
        logic [RR_MAX_NM-1:0] oh;
        logic                 found;
        int unsigned          k;
        oh    = {RR_MAX_NM{1'b0}};
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_NM; i++) begin
            if ((i < nm) && !found) begin
                k = (32'(ptr) + i) % nm;
                if (req[k]) begin
                    oh[k] = 1'b1;
                    found = 1'b1;
                end else begin
                    found = 1'b0;
                end
            end else begin
                found = found;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/mpsoc_wb_rr_sel.sv
// Combinational round-robin picker. The request vector is rotated so the
// pointer master lands on bit 0, the lowest set bit is isolated, and the
// one-hot result is rotated back into master numbering.
module mpsoc_wb_rr_sel
    import mpsoc_wb_arb_pkg::*;
#(
    parameter  int unsigned NM = 4,
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [NM-1:0] onehot_o,
    output logic          any_o
);

    logic [2*NM-1:0] dbl_req_s;
    logic [2*NM-1:0] dbl_oh_s;
    logic [NM-1:0]   rot_req_s;
    logic [NM-1:0]   rot_oh_s;
    int unsigned     back_sh_s;

    // Rotate right by ptr, keep lowest request, rotate left by ptr (as right by NM-ptr).
    always_comb begin
        dbl_req_s = {req_i, req_i};
        rot_req_s = NM'(dbl_req_s >> ptr_i);
        rot_oh_s  = rot_req_s & (~rot_req_s + NM'(1));
        dbl_oh_s  = {rot_oh_s, rot_oh_s};
        back_sh_s = NM - 32'(ptr_i);
        onehot_o  = NM'(dbl_oh_s >> back_sh_s);
        any_o     = |req_i;
    end

endmodule

// File: rtl/mpsoc_wb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter: NM masters share one slave port. A grant
// is held for the whole wb_cyc so bursts and retries are never split, and a
// per-grant watchdog terminates a strobe the slave never answers with an err.
module mpsoc_wb_arbiter_rr
    import mpsoc_wb_arb_pkg::*;
#(
    parameter int unsigned NM      = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM*3-1:0]      m_cti_i,
    input  logic [NM*2-1:0]      m_bte_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NM-1:0]        m_rty_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic [2:0]           s_cti_o,
    output logic [1:0]           s_bte_o,
    input  logic [DW-1:0]        s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic                 s_rty_i,
    output logic [NM-1:0]        gnt_o,
    output logic                 gnt_vld_o
);

    localparam int unsigned IW      = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned SW      = DW / 8;
    localparam int unsigned WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic        WD_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : {WDW{1'b0}};
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);

    arb_state_e      state_q, state_d;
    logic [NM-1:0]   gnt_q, gnt_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic [IW-1:0]   next_idx_s;
    logic [IW-1:0]   pick_ptr_s;
    logic [NM-1:0]   pick_oh_s;
    logic            pick_any_s;
    logic [IW-1:0]   pick_idx_s;
    logic            cur_cyc_s;
    logic            cur_stb_s;
    logic            resp_s;
    logic            timeout_s;

    // Current-grant status, successor index and the pointer fed to the picker.
    always_comb begin
        next_idx_s = (idx_q == IW'(NM - 1)) ? {IW{1'b0}} : (idx_q + IW'(1));
        pick_ptr_s = (state_q == ARB_BUSY) ? next_idx_s : ptr_q;
        cur_cyc_s  = gnt_vld_q & m_cyc_i[idx_q];
        cur_stb_s  = gnt_vld_q & m_stb_i[idx_q];
        resp_s     = s_ack_i | s_err_i | s_rty_i;
        timeout_s  = WD_EN & cur_stb_s & ~resp_s & (wd_q == WD_LAST);
    end

    mpsoc_wb_rr_sel #(
        .NM       (NM)
    ) u_rr_sel (
        .req_i    (m_cyc_i),
        .ptr_i    (pick_ptr_s),
        .onehot_o (pick_oh_s),
        .any_o    (pick_any_s)
    );

    // Binary index of the picked master.
    always_comb begin
        pick_idx_s = {IW{1'b0}};
        for (int unsigned k = 0; k < NM; k++) begin
            pick_idx_s = pick_idx_s | (pick_oh_s[k] ? IW'(k) : {IW{1'b0}});
        end
    end

    // Arbitration FSM: grant on any request, hold while cyc, hand over or go idle on release.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    state_d   = ARB_BUSY;
                    gnt_d     = pick_oh_s;
                    gnt_vld_d = 1'b1;
                    idx_d     = pick_idx_s;
                end else begin
                    state_d   = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (!m_cyc_i[idx_q]) begin
                    ptr_d = next_idx_s;
                    if (pick_any_s) begin
                        gnt_d = pick_oh_s;
                        idx_d = pick_idx_s;
                    end else begin
                        state_d   = ARB_IDLE;
                        gnt_d     = {NM{1'b0}};
                        gnt_vld_d = 1'b0;
                        idx_d     = {IW{1'b0}};
                    end
                end else begin
                    state_d = ARB_BUSY;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                gnt_d     = {NM{1'b0}};
                gnt_vld_d = 1'b0;
                idx_d     = {IW{1'b0}};
            end
        endcase
    end

    // Watchdog: counts unanswered strobe cycles of the current grant, saturating.
    always_comb begin
        if (!WD_EN) begin
            wd_d = {WDW{1'b0}};
        end else if ((gnt_d != gnt_q) || !cur_stb_s || resp_s || timeout_s) begin
            wd_d = {WDW{1'b0}};
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WDW'(1);
        end else begin
            wd_d = wd_q;
        end
    end

    // State, grant, pointer and watchdog registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= {NM{1'b0}};
            gnt_vld_q <= 1'b0;
            idx_q     <= {IW{1'b0}};
            ptr_q     <= {IW{1'b0}};
            wd_q      <= {WDW{1'b0}};
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
        end
    end

    // Slave-side mux of the granted master; everything low when no grant.
    always_comb begin
        if (gnt_vld_q) begin
            s_adr_o = m_adr_i[32'(idx_q) * AW +: AW];
            s_dat_o = m_dat_i[32'(idx_q) * DW +: DW];
            s_sel_o = m_sel_i[32'(idx_q) * SW +: SW];
            s_we_o  = m_we_i[idx_q];
            s_cti_o = m_cti_i[32'(idx_q) * 3 +: 3];
            s_bte_o = m_bte_i[32'(idx_q) * 2 +: 2];
        end else begin
            s_adr_o = {AW{1'b0}};
            s_dat_o = {DW{1'b0}};
            s_sel_o = {SW{1'b0}};
            s_we_o  = 1'b0;
            s_cti_o = 3'b000;
            s_bte_o = 2'b00;
        end
        s_cyc_o = cur_cyc_s & ~timeout_s;
        s_stb_o = cur_stb_s & ~timeout_s;
    end

    // Responses go to the granted master only; a watchdog expiry appears as err.
    always_comb begin
        m_dat_o   = s_dat_i;
        m_ack_o   = gnt_q & {NM{s_ack_i & gnt_vld_q}};
        m_err_o   = gnt_q & {NM{(s_err_i & gnt_vld_q) | timeout_s}};
        m_rty_o   = gnt_q & {NM{s_rty_i & gnt_vld_q}};
        gnt_o     = gnt_q;
        gnt_vld_o = gnt_vld_q;
    end

endmodule

// File: tb/tb_mpsoc_wb_arbiter_rr.sv
// Randomised bench for mpsoc_wb_arbiter_rr: four bursting masters, a slave
// with normal and unresponsive phases, occasional reset pulses. A reference
// model predicts grant events (queued) and per-cycle mux/response values.
module tb_mpsoc_wb_arbiter_rr;
    import mpsoc_wb_arb_pkg::*;

    localparam int NM      = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 16;
    localparam int NCYC    = 4000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*SW-1:0]  m_sel;
    logic [NM-1:0]     m_we, m_cyc, m_stb;
    logic [NM*3-1:0]   m_cti;
    logic [NM*2-1:0]   m_bte;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic [DW-1:0]     s_dat;
    logic              s_ack, s_err, s_rty;
    logic [NM-1:0]     gnt_o;
    logic              gnt_vld_o;

    mpsoc_wb_arbiter_rr #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .gnt_o(gnt_o), .gnt_vld_o(gnt_vld_o)
    );

    always #5 clk = ~clk;

    typedef struct { int gnt; int cyc; } gev_t;
    gev_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc_n      = 0;
    bit mon_en     = 1'b0;

    // reference model state: owner -1 means nobody granted
    int mdl_owner = -1;
    int mdl_ptr   = 0;
    int mdl_cnt   = 0;

    // master stimulus state
    bit   active[NM];
    int   beats_left[NM];
    int   gap[NM];
    int   done_cnt[NM];
    logic [NM-1:0] resp_seen, rty_seen;
    bit   slave_dead = 1'b0;
    bit   force_all  = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc_n);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc_n);
        end
    endtask

    function automatic int first_req(input logic [NM-1:0] req, input int from);
        for (int i = 0; i < NM; i++) begin
            if (req[(from + i) % NM]) return (from + i) % NM;
        end
        return -1;
    endfunction

    function automatic bit model_timeout();
        return (mdl_owner >= 0) && (m_stb[mdl_owner] == 1'b1) &&
               !(s_ack || s_err || s_rty) && (mdl_cnt == TIMEOUT - 1);
    endfunction

    function automatic int enc_gnt();
        logic [NM-1:0] one;
        one = {{(NM-1){1'b0}}, 1'b1};
        if (gnt_vld_o === 1'b0) return (gnt_o === {NM{1'b0}}) ? -1 : -3;
        if (gnt_vld_o !== 1'b1) return -4;
        for (int k = 0; k < NM; k++) begin
            if (gnt_o === (one << k)) return k;
        end
        return -2;
    endfunction

    // Reference model: advances at every rising edge from the values the DUT samples.
    initial begin
        int  nxt;
        bit  to, stb, rsp;
        forever begin
            @(posedge clk);
            cyc_n++;
            to  = model_timeout();
            stb = (mdl_owner >= 0) && (m_stb[mdl_owner] == 1'b1);
            rsp = s_ack || s_err || s_rty;
            if (!rst_n) begin
                nxt     = -1;
                mdl_ptr = 0;
            end else if (mdl_owner < 0) begin
                nxt = first_req(m_cyc, mdl_ptr);
            end else if (!m_cyc[mdl_owner]) begin
                mdl_ptr = (mdl_owner + 1) % NM;
                nxt     = first_req(m_cyc, mdl_ptr);
            end else begin
                nxt = mdl_owner;
            end
            if (!rst_n || (nxt != mdl_owner) || !stb || rsp || to) mdl_cnt = 0;
            else mdl_cnt++;
            if (nxt != mdl_owner) exp_q.push_back('{gnt: nxt, cyc: cyc_n});
            mdl_owner = nxt;
        end
    end

    // Monitor: pops grant events when the DUT's grant changes, checks muxes every cycle.
    initial begin
        int   obs, last_obs, own;
        bit   to;
        gev_t e;
        logic [NM-1:0] one, w_ack, w_err, w_rty;
        logic [127:0]  w_fields;
        one = {{(NM-1){1'b0}}, 1'b1};
        wait (mon_en);
        @(negedge clk);
        obs = enc_gnt();
        check_int("reset_gnt", obs, -1);
        check("reset_s_ctl", {s_cyc_o, s_stb_o}, 128'd0);
        last_obs = obs;
        forever begin
            @(negedge clk);
            obs = enc_gnt();
            if (obs != last_obs) begin
                if (exp_q.size() == 0) begin
                    check_int("gnt_spurious", obs, last_obs);
                end else begin
                    e = exp_q.pop_front();
                    check_int("gnt_seq", obs, e.gnt);
                    check_int("gnt_time", cyc_n, e.cyc);
                end
            end
            last_obs = obs;
            own = mdl_owner;
            to  = model_timeout();
            w_ack = {NM{1'b0}};
            w_err = {NM{1'b0}};
            w_rty = {NM{1'b0}};
            w_fields = 128'd0;
            if (own >= 0) begin
                w_fields = {m_adr[own*AW +: AW], m_dat[own*DW +: DW], m_sel[own*SW +: SW],
                            m_we[own], m_cti[own*3 +: 3], m_bte[own*2 +: 2]};
                if (s_ack) w_ack = one << own;
                if (s_err || to) w_err = one << own;
                if (s_rty) w_rty = one << own;
            end
            check("s_ctl", {s_cyc_o, s_stb_o},
                  {126'd0, (own >= 0) && m_cyc[own] && !to, (own >= 0) && m_stb[own] && !to});
            check("s_fields", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o}, w_fields);
            check("m_resp", {m_ack_o, m_err_o, m_rty_o}, {w_ack, w_err, w_rty});
            check("m_dat", m_dat_o, s_dat);
        end
    end

    // Stimulus: masters, slave and reset pulses.
    initial begin
        int r;
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
        m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        for (int k = 0; k < NM; k++) begin
            active[k] = 1'b0; beats_left[k] = 0; gap[k] = 0; done_cnt[k] = 0;
        end
        repeat (5) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        force_all = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            resp_seen = m_ack_o | m_err_o | m_rty_o;
            rty_seen  = m_rty_o;
            @(posedge clk);
            #1;
            rst_n      = !((c > 50) && ($urandom_range(0, 299) == 0));
            slave_dead = ((c / 250) % 2) == 1;
            for (int k = 0; k < NM; k++) begin
                if (active[k]) begin
                    if (resp_seen[k] && !rty_seen[k]) begin
                        beats_left[k]--;
                        if (beats_left[k] == 0) begin
                            active[k] = 1'b0;
                            done_cnt[k]++;
                            gap[k] = $urandom_range(0, 2);
                        end else begin
                            m_adr[k*AW +: AW] = m_adr[k*AW +: AW] + 32'd4;
                            m_dat[k*DW +: DW] = $urandom;
                            m_cti[k*3 +: 3]   = (beats_left[k] == 1) ? CTI_EOB : CTI_INCR;
                        end
                    end
                end else if (gap[k] > 0) begin
                    gap[k]--;
                end else if (force_all || ($urandom_range(0, 3) == 0)) begin
                    active[k]     = 1'b1;
                    beats_left[k] = $urandom_range(1, 8);
                    m_adr[k*AW +: AW] = {$urandom_range(0, 65535), 16'h0000} | (32'(k) << 8);
                    m_dat[k*DW +: DW] = $urandom;
                    m_sel[k*SW +: SW] = 4'(($urandom_range(0, 14)) + 1);
                    m_we[k]           = $urandom_range(0, 1) == 1;
                    m_cti[k*3 +: 3]   = (beats_left[k] == 1) ? CTI_CLASSIC : CTI_INCR;
                    m_bte[k*2 +: 2]   = BTE_LINEAR;
                end
                m_cyc[k] = active[k];
                m_stb[k] = active[k] && (slave_dead || ($urandom_range(0, 7) != 0));
            end
            force_all = 1'b0;
            #1;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            s_dat = $urandom;
            if ((gnt_o & m_stb & m_cyc) != {NM{1'b0}}) begin
                r = $urandom_range(0, 99);
                if (!slave_dead) begin
                    if (r < 70) s_ack = 1'b1;
                    else if (r < 76) s_err = 1'b1;
                    else if (r < 82) s_rty = 1'b1;
                end else if (r < 4) begin
                    s_ack = 1'b1;
                end
            end
        end
        @(negedge clk);
        #1;
        check_int("events_drained", exp_q.size(), 0);
        check_int("final_owner", enc_gnt(), mdl_owner);
        for (int k = 0; k < NM; k++) begin
            check_int($sformatf("served_m%0d", k), int'(done_cnt[k] > 0), 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
